// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Buffered UART transmitter: a byte FIFO feeds a serialiser whose framing is
// captured from uart_config_i each time it leaves IDLE (frame or break).
package uart_tx_fifo_pkg;
    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_e;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
    typedef enum logic [1:0] {STOP_1 = 2'd0, STOP_1_5 = 2'd1, STOP_2 = 2'd2} stop_e;
    typedef struct packed {
        baud_e      baud_rate;
        logic [1:0] data_bits;  // frame carries data_bits+5 bits
        parity_e    parity;
        stop_e      stop_bits;
        logic       lsb_first;
    } uart_config_t;
endpackage

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 1843200,
    parameter int FIFO_DEPTH = 16,
    parameter int BREAK_BITS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  uart_config_t                uart_config_i,
    input  logic                        tx_en_i,
    input  logic                        wr_valid_i,
    input  logic [7:0]                  wr_data_i,
    output logic                        wr_ready_o,
    input  logic                        send_break_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        fifo_empty_o,
    output logic                        fifo_full_o,
    output logic                        frame_done_o,
    output logic                        overflow_o
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CPB_MAX = CLK_FREQ / 9600;
    localparam int CNT_W   = $clog2(2 * CPB_MAX + 1);  // also holds a 2-bit stop period
    localparam int BRK_W   = $clog2(BREAK_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

    function automatic logic [CNT_W-1:0] cpb_of(input baud_e baud);
        int rate;
        case (baud)
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            default:     rate = 9600;
        endcase
        return CNT_W'(CLK_FREQ / rate);
    endfunction

    function automatic logic [CNT_W-1:0] stop_of(input stop_e stop, input logic [CNT_W-1:0] cpb);
        int c;
        c = int'(cpb);
        case (stop)
            STOP_1_5: return CNT_W'((3 * c) / 2);
            STOP_2:   return CNT_W'(2 * c);
            default:  return CNT_W'(c);
        endcase
    endfunction

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, empty_q, overflow_q;
    logic             push, pop;
    logic [7:0]       data_q;

    assign push = wr_valid_i && !full_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q    <= level_d;
            full_q     <= (level_d == LVL_W'(FIFO_DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= wr_valid_i && full_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (pop) data_q <= mem[rd_ptr_q];
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cpb_q, cpb_d, stop_q, stop_d, target;
    logic [2:0]       bit_q, bit_d, bit_sel, last_bit;
    logic [BRK_W-1:0] brk_q, brk_d;
    logic [1:0]       nbits_q, nbits_d;
    parity_e          par_q, par_d;
    logic             lsb_q, lsb_d, brk_frame_q, brk_frame_d;
    logic             tx_q, tx_d, done_q, done_d, last, par_bit;
    logic [7:0]       mask;

    assign last_bit = {1'b0, nbits_q} + 3'd4;
    assign mask     = 8'hFF >> (2'd3 - nbits_q);
    assign par_bit  = (^(data_q & mask)) ^ (par_q == PAR_ODD);
    assign target   = (state_q == S_STOP) ? stop_q : cpb_q;
    assign last     = (cnt_q == target - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        brk_d       = brk_q;
        cpb_d       = cpb_q;
        stop_d      = stop_q;
        nbits_d     = nbits_q;
        par_d       = par_q;
        lsb_d       = lsb_q;
        brk_frame_d = brk_frame_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        tx_d        = 1'b1;
        bit_sel     = '0;
        if (state_q != S_IDLE) cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                // Break wins over data and does not need tx_en.
                if (send_break_i || (tx_en_i && !empty_q)) begin
                    cpb_d       = cpb_of(uart_config_i.baud_rate);
                    stop_d      = stop_of(uart_config_i.stop_bits, cpb_d);
                    nbits_d     = uart_config_i.data_bits;
                    par_d       = uart_config_i.parity;
                    lsb_d       = uart_config_i.lsb_first;
                    cnt_d       = '0;
                    bit_d       = '0;
                    brk_d       = '0;
                    brk_frame_d = send_break_i;
                    pop         = !send_break_i;
                    state_d     = send_break_i ? S_BREAK : S_START;
                end
            end
            S_START: if (last) state_d = S_DATA;
            S_DATA: begin
                if (last) begin
                    if (bit_q == last_bit)
                        state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? S_PARITY : S_STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            S_PARITY: if (last) state_d = S_STOP;
            S_STOP: begin
                if (last) begin
                    state_d = S_IDLE;
                    done_d  = !brk_frame_q;
                end
            end
            S_BREAK: begin
                if (last && brk_q != BRK_W'(BREAK_BITS)) brk_d = brk_q + BRK_W'(1);
                if (!send_break_i && brk_d == BRK_W'(BREAK_BITS)) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level is registered from the next state so tx never glitches.
        bit_sel = lsb_q ? bit_d : last_bit - bit_d;
        case (state_d)
            S_START, S_BREAK: tx_d = 1'b0;
            S_DATA:           tx_d = data_q[bit_sel];
            S_PARITY:         tx_d = par_bit;
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            brk_q       <= '0;
            cpb_q       <= '0;
            stop_q      <= '0;
            nbits_q     <= '0;
            par_q       <= PAR_NONE;
            lsb_q       <= 1'b0;
            brk_frame_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            brk_q       <= brk_d;
            cpb_q       <= cpb_d;
            stop_q      <= stop_d;
            nbits_q     <= nbits_d;
            par_q       <= par_d;
            lsb_q       <= lsb_d;
            brk_frame_q <= brk_frame_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != S_IDLE);
    assign fifo_level_o = level_q;
    assign fifo_empty_o = empty_q;
    assign fifo_full_o  = full_q;
    assign wr_ready_o   = !full_q;
    assign frame_done_o = done_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_fifo: each frame or break is predicted as a
// per-clock line waveform built from the framing rules and compared cycle by cycle.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int CLK_FREQ   = 1843200;
    localparam int FIFO_DEPTH = 16;
    localparam int BREAK_BITS = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    uart_config_t cfg;
    logic         tx_en = 1'b0;
    logic         wr_valid = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         send_break = 1'b0;
    logic         wr_ready, tx, busy, fifo_empty, fifo_full, frame_done, overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(FIFO_DEPTH), .BREAK_BITS(BREAK_BITS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .uart_config_i(cfg), .tx_en_i(tx_en),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .send_break_i(send_break), .tx_o(tx), .busy_o(busy), .fifo_level_o(fifo_level),
        .fifo_empty_o(fifo_empty), .fifo_full_o(fifo_full), .frame_done_o(frame_done),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_cpb(input baud_e b);
        int rate;
        case (b)
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            default:     rate = 9600;
        endcase
        return CLK_FREQ / rate;
    endfunction

    function automatic int model_stop(input uart_config_t c);
        int cpb;
        cpb = model_cpb(c.baud_rate);
        if (c.stop_bits == STOP_1_5) return (3 * cpb) / 2;
        if (c.stop_bits == STOP_2)   return 2 * cpb;
        return cpb;
    endfunction

    function automatic uart_config_t make_cfg(input baud_e b, input logic [1:0] db,
                                              input parity_e p, input stop_e s, input logic lsb);
        uart_config_t c;
        c.baud_rate = b;
        c.data_bits = db;
        c.parity    = p;
        c.stop_bits = s;
        c.lsb_first = lsb;
        return c;
    endfunction

    function automatic uart_config_t rand_cfg();
        uart_config_t c;
        if ($urandom_range(0, 3) == 0) c.baud_rate = baud_e'(3'($urandom_range(0, 7)));
        else c.baud_rate = ($urandom_range(0, 1) == 1) ? BAUD_115200 : BAUD_57600;
        c.data_bits = 2'($urandom_range(0, 3));
        c.parity    = parity_e'(2'($urandom_range(0, 2)));
        c.stop_bits = stop_e'(2'($urandom_range(0, 2)));
        c.lsb_first = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Enqueue one byte; starts and ends on a falling clock edge.
    task automatic push(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at the falling edge of the first START cycle; returns in the idle cycle after STOP.
    task automatic run_frame(input uart_config_t c, input logic [7:0] b,
                             input bit do_mid, input uart_config_t mid_cfg);
        logic exp_q[$];
        int   cpb, n, errs, k, len;
        logic [7:0] m, dec;
        logic pbit;
        cpb  = model_cpb(c.baud_rate);
        n    = int'(c.data_bits) + 5;
        m    = 8'((1 << n) - 1);
        errs = 0;
        dec  = 8'h00;
        repeat (cpb) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            pbit = c.lsb_first ? b[i] : b[n - 1 - i];
            repeat (cpb) exp_q.push_back(pbit);
        end
        if (c.parity != PAR_NONE) begin
            pbit = 1'($countones(b & m) % 2) ^ (c.parity == PAR_ODD);
            repeat (cpb) exp_q.push_back(pbit);
        end
        repeat (model_stop(c)) exp_q.push_back(1'b1);
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            if (tx !== exp_q[i] || frame_done !== 1'b0 || busy !== 1'b1) errs++;
            if (i >= cpb && i < cpb * (n + 1) && (i - cpb) % cpb == cpb / 2) begin
                k = (i - cpb) / cpb;
                dec[c.lsb_first ? k : n - 1 - k] = tx;
            end
            if (do_mid && i == len / 2) cfg = mid_cfg;
            @(negedge clk);
        end
        $display("frame data=0x%02h bits=%0d parity=%0d stop=%0d lsb=%0d cpb=%0d clocks=%0d cycle_errors=%0d",
                 b & m, n, c.parity, c.stop_bits, c.lsb_first, cpb, len, errs);
        check("frame_wave", errs, 0);
        check("frame_data", dec, b & m);
        check("frame_done", frame_done, 1);
        check("frame_busy_end", busy, 0);
        check("frame_tx_idle", tx, 1);
    endtask

    task automatic send_one(input uart_config_t c, input logic [7:0] b, input bit do_mid);
        cfg = c;
        push(b);
        check("start_latency", tx, 1);
        @(negedge clk);
        run_frame(c, b, do_mid, rand_cfg());
    endtask

    // Called at a falling edge while idle with an empty FIFO.
    task automatic run_break(input uart_config_t c, input int hold, input logic [7:0] b);
        int blen, slen, errs, dones;
        cfg        = c;
        tx_en      = 1'b1;
        send_break = 1'b1;
        @(negedge clk);
        blen  = (hold > BREAK_BITS * model_cpb(c.baud_rate)) ? hold : BREAK_BITS * model_cpb(c.baud_rate);
        slen  = model_stop(c);
        errs  = 0;
        dones = 0;
        for (int i = 0; i < blen + slen; i++) begin
            if (tx !== ((i < blen) ? 1'b0 : 1'b1) || busy !== 1'b1) errs++;
            if (frame_done === 1'b1) dones++;
            if (i == hold - 1) send_break = 1'b0;
            if (i == 100) begin
                wr_valid = 1'b1;
                wr_data  = b;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        $display("break hold=%0d low=%0d stop=%0d cycle_errors=%0d", hold, blen, slen, errs);
        check("break_wave", errs, 0);
        check("break_no_done", dones + int'(frame_done), 0);
        check("break_idle_tx", tx, 1);
        check("break_idle_busy", busy, 0);
        @(negedge clk);
        run_frame(c, b, 1'b0, c);
    endtask

    initial begin
        uart_config_t c, c2;
        logic [7:0] bytes [FIFO_DEPTH];
        logic [7:0] a, b;
        int errs;

        cfg = make_cfg(BAUD_115200, 2'd3, PAR_NONE, STOP_1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_en = 1'b1;

        send_one(make_cfg(BAUD_115200, 2'd3, PAR_NONE, STOP_1, 1'b1), 8'hA5, 1'b0);
        send_one(make_cfg(BAUD_115200, 2'd2, PAR_EVEN, STOP_1, 1'b0), 8'h5A, 1'b0);
        send_one(make_cfg(BAUD_115200, 2'd2, PAR_ODD,  STOP_1, 1'b0), 8'h5A, 1'b0);

        // Config switched mid-DATA only affects the following frame.
        c  = make_cfg(BAUD_115200, 2'd3, PAR_NONE, STOP_2, 1'b1);
        c2 = make_cfg(BAUD_9600,   2'd3, PAR_NONE, STOP_1, 1'b1);
        a  = 8'($urandom);
        b  = 8'($urandom);
        tx_en = 1'b0;
        cfg   = c;
        push(a);
        push(b);
        tx_en = 1'b1;
        @(negedge clk);
        run_frame(c, a, 1'b1, c2);
        @(negedge clk);
        run_frame(c2, b, 1'b0, c2);

        for (int r = 0; r < 8; r++) send_one(rand_cfg(), 8'($urandom), 1'b1);

        // Push and pop on the same edge leave the level unchanged.
        c = make_cfg(BAUD_115200, 2'd3, PAR_NONE, STOP_1, 1'b1);
        cfg   = c;
        tx_en = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        push(a);
        wr_valid = 1'b1;
        wr_data  = b;
        tx_en    = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("level_push_pop", fifo_level, 1);
        run_frame(c, a, 1'b0, c);
        @(negedge clk);
        run_frame(c, b, 1'b0, c);

        // Fill, overflow, then drain back-to-back.
        tx_en = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            bytes[k] = 8'($urandom);
            push(bytes[k]);
        end
        check("full_after_fill", fifo_full, 1);
        check("level_after_fill", fifo_level, FIFO_DEPTH);
        check("wr_ready_full", wr_ready, 0);
        check("empty_when_full", fifo_empty, 0);
        push(8'hEE);
        check("overflow_17th", overflow, 1);
        check("level_17th", fifo_level, FIFO_DEPTH);
        @(negedge clk);
        check("overflow_one_cycle", overflow, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tx_en    = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("overflow_full_pop", overflow, 1);
        check("level_full_pop", fifo_level, FIFO_DEPTH - 1);
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            check("level_drain", fifo_level, FIFO_DEPTH - 1 - k);
            run_frame(c, bytes[k], 1'b0, c);
            if (k != FIFO_DEPTH - 1) @(negedge clk);
        end
        check("empty_after_drain", fifo_empty, 1);

        run_break(make_cfg(BAUD_115200, 2'd3, PAR_NONE, stop_e'(2'($urandom_range(0, 2))), 1'b1), 50, 8'($urandom));
        run_break(make_cfg(BAUD_115200, 2'd3, PAR_EVEN, stop_e'(2'($urandom_range(0, 2))), 1'b0), 300, 8'($urandom));

        // Reset mid-DATA with bytes still queued.
        tx_en = 1'b0;
        cfg   = c;
        for (int k = 0; k < 4; k++) push(8'($urandom));
        tx_en = 1'b1;
        @(negedge clk);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_empty", fifo_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
            @(negedge clk);
        end
        check("post_reset_quiet", errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
